// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle fetch/decode/execute control sequencer for the basic CPU
// Optional single-step PAUSE state is enabled by defining CPU_CTRL_SINGLE_STEP_EN.
module cpu_ctrl_fsm #(
    parameter int          CNT_W     = 8,
    parameter int unsigned MAX_INSTR = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [8:0]       instruction,
    input  logic [15:0]      data_var,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic             dbg_single,
    input  logic             dbg_go,
`endif
    output logic             step,
    output logic [2:0]       rx_sel,
    output logic [2:0]       ry_sel,
    output logic [15:0]      imm_out,
    output logic [1:0]       wr_src,
    output logic             alu_op,
    output logic             alu_en,
    output logic             reg_we,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_WB     = 4'd4,
        S_ADV    = 4'd5,
        S_SETTLE = 4'd6,
        S_HALT   = 4'd7,
        S_PAUSE  = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ir_op_q, ir_op_d;
    logic [15:0]      imm_q, imm_d;
    logic [2:0]       rx_sel_q, rx_sel_d;
    logic [2:0]       ry_sel_q, ry_sel_d;
    logic [1:0]       wr_src_q, wr_src_d;
    logic             alu_op_q, alu_op_d;
    logic             alu_en_q, alu_en_d;
    logic             reg_we_q, reg_we_d;
    logic             step_q, step_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             wd_hit;

    assign wd_hit = (MAX_INSTR != 0) && (32'(cnt_q) == MAX_INSTR);

    always_comb begin
        state_d   = state_q;
        ir_op_d   = ir_op_q;
        imm_d     = imm_q;
        rx_sel_d  = rx_sel_q;
        ry_sel_d  = ry_sel_q;
        wr_src_d  = wr_src_q;
        alu_op_d  = alu_op_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                // Operand fields are captured here so they stay stable through ADV.
                ir_op_d  = instruction[8:6];
                imm_d    = data_var;
                rx_sel_d = instruction[5:3];
                ry_sel_d = instruction[2:0];
                case (instruction[8:6])
                    3'd0:    wr_src_d = 2'b00;
                    3'd1:    wr_src_d = 2'b01;
                    3'd2,
                    3'd3:    wr_src_d = 2'b10;
                    default: wr_src_d = 2'b00;
                endcase
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (ir_op_q)
                    3'd0, 3'd1: state_d = S_WB;
                    3'd2, 3'd3: begin
                        alu_op_d = ir_op_q[0];
                        state_d  = S_EXEC;
                    end
                    3'd4:       state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_ADV;
            end
            S_ADV: begin
                if (wd_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
`ifdef CPU_CTRL_SINGLE_STEP_EN
                    state_d = dbg_single ? S_PAUSE : S_SETTLE;
`else
                    state_d = S_SETTLE;
`endif
                end
            end
`ifdef CPU_CTRL_SINGLE_STEP_EN
            S_PAUSE: begin
                if (dbg_go) state_d = S_SETTLE;
            end
`endif
            S_SETTLE: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        // Strobes are decoded from the next state so they appear registered in that state.
        step_d   = (state_d == S_ADV);
        reg_we_d = (state_d == S_WB);
        alu_en_d = (state_d == S_EXEC);
        halted_d = (state_d == S_HALT);
        busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ir_op_q   <= '0;
            imm_q     <= '0;
            rx_sel_q  <= '0;
            ry_sel_q  <= '0;
            wr_src_q  <= '0;
            alu_op_q  <= 1'b0;
            alu_en_q  <= 1'b0;
            reg_we_q  <= 1'b0;
            step_q    <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ir_op_q   <= ir_op_d;
            imm_q     <= imm_d;
            rx_sel_q  <= rx_sel_d;
            ry_sel_q  <= ry_sel_d;
            wr_src_q  <= wr_src_d;
            alu_op_q  <= alu_op_d;
            alu_en_q  <= alu_en_d;
            reg_we_q  <= reg_we_d;
            step_q    <= step_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign step        = step_q;
    assign rx_sel      = rx_sel_q;
    assign ry_sel      = ry_sel_q;
    assign imm_out     = imm_q;
    assign wr_src      = wr_src_q;
    assign alu_op      = alu_op_q;
    assign alu_en      = alu_en_q;
    assign reg_we      = reg_we_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign instr_count = cnt_q;

endmodule
